// File: rtl/uart_pkg.sv
// Shared types and helpers for the buffered UART transmitter.
package uart_pkg;

    // Transmit FSM states.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity mode select values on Par_Odd.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Clock cycles occupied by one frame on the line.
    function automatic int unsigned frame_cycles(
        input int unsigned data_w,
        input int unsigned baud_div,
        input logic        par_en,
        input logic        stop2
    );
        return baud_div * (32'd2 + data_w + 32'(par_en) + 32'(stop2));
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Circular-buffer FIFO with a count register; pointers wrap naturally.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since the count guards reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_piso.sv
// Buffered UART transmitter: FIFO-fed framer with start, optional parity and 1/2 stop bits.
module uart_tx_piso
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter bit          MSB_FIRST  = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] Tx_Data,
    input  logic              Tx_Valid,
    output logic              Tx_Ready,
    input  logic              Par_En,
    input  logic              Par_Odd,
    input  logic              Stop2,
    input  logic              Clr_Err,
    output logic              Serial_Out,
    output logic              Busy,
    output logic              Tx_Done,
    output logic              Fifo_Empty,
    output logic              Ovf_Err
);

    localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              par_en_q, par_en_d;
    logic              par_odd_q, par_odd_d;
    logic              stop2_q, stop2_d;
    logic              serial_q, serial_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;

    logic              fifo_push_c;
    logic              fifo_pop_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              baud_last_c;
    logic              stop_last_c;
    logic              par_bit_c;
    logic              cur_bit_c;

    // Words are queued here; the FSM pops the head at frame start.
    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .push    (fifo_push_c),
        .pop     (fifo_pop_c),
        .wr_data (Tx_Data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign Tx_Ready    = !fifo_full || fifo_pop_c;
    assign fifo_push_c = Tx_Valid && Tx_Ready;
    assign Fifo_Empty  = fifo_empty;
    assign Serial_Out  = serial_q;
    assign Busy        = busy_q;
    assign Tx_Done     = done_q;
    assign Ovf_Err     = ovf_q;

    assign baud_last_c = (baud_q == BAUD_W'(BAUD_DIV - 1));
    assign stop_last_c = (bit_q == BIT_W'(stop2_q));

    // Next-state logic, baud/bit counters, shift register and frame config latch.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q + BAUD_W'(1);
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        word_d     = word_q;
        par_en_d   = par_en_q;
        par_odd_d  = par_odd_q;
        stop2_d    = stop2_q;
        done_d     = 1'b0;
        fifo_pop_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (!fifo_empty) begin
                    fifo_pop_c = 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (baud_last_c) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_DATA: begin
                if (baud_last_c) begin
                    baud_d  = '0;
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d   = '0;
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (baud_last_c) begin
                    state_d = ST_STOP;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            ST_STOP: begin
                // Registered pulse lands in the final cycle of the last stop bit.
                if (stop_last_c && (baud_q == BAUD_W'(BAUD_DIV - 2))) begin
                    done_d = 1'b1;
                end
                if (baud_last_c) begin
                    baud_d = '0;
                    if (stop_last_c) begin
                        bit_d = '0;
                        if (!fifo_empty) begin
                            fifo_pop_c = 1'b1;
                            state_d    = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                baud_d  = '0;
                bit_d   = '0;
            end
        endcase

        // Word and line settings are frozen for the whole frame at pop time.
        if (fifo_pop_c) begin
            shreg_d   = fifo_rd_data;
            word_d    = fifo_rd_data;
            par_en_d  = Par_En;
            par_odd_d = Par_Odd;
            stop2_d   = Stop2;
        end
    end

    // Line level, busy and sticky overflow, all computed one cycle ahead of the flops.
    always_comb begin
        par_bit_c = (^word_q) ^ (par_odd_q == PAR_ODD);
        cur_bit_c = MSB_FIRST ? shreg_d[DATA_W-1] : shreg_d[0];
        serial_d  = 1'b1;
        case (state_d)
            ST_IDLE:   serial_d = 1'b1;
            ST_START:  serial_d = 1'b0;
            ST_DATA:   serial_d = cur_bit_c;
            ST_PARITY: serial_d = par_bit_c;
            default:   serial_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
        ovf_d  = ovf_q;
        if (Clr_Err) begin
            ovf_d = 1'b0;
        end
        if (Tx_Valid && !Tx_Ready) begin
            ovf_d = 1'b1;
        end
    end

    // State, datapath and output registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            word_q    <= '0;
            par_en_q  <= 1'b0;
            par_odd_q <= 1'b0;
            stop2_q   <= 1'b0;
            serial_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            word_q    <= word_d;
            par_en_q  <= par_en_d;
            par_odd_q <= par_odd_d;
            stop2_q   <= stop2_d;
            serial_q  <= serial_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_piso.sv
// Scoreboard bench: LSB-first and MSB-first instances share stimulus; monitors decode frames.
`timescale 1ns/1ps
module tb_uart_tx_piso;

    localparam int DW = 8;
    localparam int BD = 4;
    localparam int FD = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic          pe;
        logic          odd;
        logic          s2;
    } exp_t;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic [DW-1:0] Tx_Data = '0;
    logic          Tx_Valid = 1'b0;
    logic          Par_En = 1'b0;
    logic          Par_Odd = 1'b0;
    logic          Stop2 = 1'b0;
    logic          Clr_Err = 1'b0;

    logic ready [2];
    logic ser   [2];
    logic busy  [2];
    logic done  [2];
    logic empty [2];
    logic ovf   [2];

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_acc    = 0;
    bit   started  = 1'b0;

    always #5 Clk = ~Clk;

    uart_tx_piso #(.DATA_W(DW), .BAUD_DIV(BD), .FIFO_DEPTH(FD), .MSB_FIRST(1'b0)) u_lsb (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(ready[0]),
        .Par_En(Par_En), .Par_Odd(Par_Odd), .Stop2(Stop2), .Clr_Err(Clr_Err),
        .Serial_Out(ser[0]), .Busy(busy[0]), .Tx_Done(done[0]), .Fifo_Empty(empty[0]),
        .Ovf_Err(ovf[0])
    );

    uart_tx_piso #(.DATA_W(DW), .BAUD_DIV(BD), .FIFO_DEPTH(FD), .MSB_FIRST(1'b1)) u_msb (
        .Clk(Clk), .Rst(Rst), .Tx_Data(Tx_Data), .Tx_Valid(Tx_Valid), .Tx_Ready(ready[1]),
        .Par_En(Par_En), .Par_Odd(Par_Odd), .Stop2(Stop2), .Clr_Err(Clr_Err),
        .Serial_Out(ser[1]), .Busy(busy[1]), .Tx_Done(done[1]), .Fifo_Empty(empty[1]),
        .Ovf_Err(ovf[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s", name);
    endtask

    // Reference: k-th bit period of a frame, derived from the framing rules.
    function automatic logic frame_bit(input exp_t e, input int k, input bit msb);
        if (k == 0) return 1'b0;
        if (k <= DW) return msb ? e.data[DW-k] : e.data[k-1];
        if (k == DW + 1 && e.pe) return ((($countones(e.data) % 2) == 1) ? 1'b1 : 1'b0) ^ e.odd;
        return 1'b1;
    endfunction

    // Frame monitor: decodes every frame on the line and checks it against the queue head.
    task automatic monitor(input int idx, input bit msb);
        exp_t e;
        int   nb, len, mism, done_at, done_n, busy_lo, pos;
        logic [31:0] rxw;
        bit   aborted;
        bit   after_frame = 1'b0;
        forever begin
            @(negedge Clk);
            if (Rst || !started) begin
                after_frame = 1'b0;
                continue;
            end
            if (ser[idx] === 1'b1) begin
                if (after_frame) chk($sformatf("busy_fall[%0d]", idx), 32'(busy[idx]), 32'd0);
                after_frame = 1'b0;
                continue;
            end
            after_frame = 1'b0;
            if ((idx == 0 && q0.size() == 0) || (idx == 1 && q1.size() == 0)) begin
                fail($sformatf("unexpected_frame[%0d] line low with nothing queued", idx));
                continue;
            end
            if (idx == 0) e = q0.pop_front();
            else          e = q1.pop_front();
            nb      = 2 + DW + int'(e.pe) + int'(e.s2);
            len     = BD * nb;
            mism    = 0;
            done_at = -1;
            done_n  = 0;
            busy_lo = 0;
            rxw     = '0;
            aborted = 1'b0;
            for (int c = 0; c < len; c++) begin
                if (c > 0) begin
                    @(negedge Clk);
                    if (Rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (ser[idx] !== frame_bit(e, c / BD, msb)) mism++;
                if (done[idx] === 1'b1) begin
                    done_n++;
                    if (done_at < 0) done_at = c;
                end
                if (busy[idx] !== 1'b1) busy_lo++;
                if (c / BD >= 1 && c / BD <= DW && c % BD == BD / 2) begin
                    pos = msb ? (DW - (c / BD)) : (c / BD - 1);
                    rxw[pos] = ser[idx];
                end
            end
            if (!aborted) begin
                chk($sformatf("frame_data[%0d]", idx), rxw, 32'(e.data));
                chk($sformatf("line_err_cycles[%0d]", idx), 32'(mism), 32'd0);
                chk($sformatf("tx_done_cycle[%0d]", idx), 32'(done_at), 32'(len - 1));
                chk($sformatf("tx_done_count[%0d]", idx), 32'(done_n), 32'd1);
                chk($sformatf("busy_low_cycles[%0d]", idx), 32'(busy_lo), 32'd0);
                after_frame = 1'b1;
            end
        end
    endtask

    initial monitor(0, 1'b0);
    initial monitor(1, 1'b1);

    // Handshake scoreboard: accepted words enter the queues; sticky overflow model.
    initial begin : sb
        logic ovf_m;
        exp_t e;
        ovf_m = 1'b0;
        forever begin
            @(negedge Clk);
            if (!started) continue;
            chk("ovf_err[0]", 32'(ovf[0]), 32'(ovf_m));
            chk("ovf_err[1]", 32'(ovf[1]), 32'(ovf_m));
            if (Rst) begin
                ovf_m = 1'b0;
            end else begin
                if (Tx_Valid && ready[0] === 1'b1) begin
                    e.data = Tx_Data;
                    e.pe   = Par_En;
                    e.odd  = Par_Odd;
                    e.s2   = Stop2;
                    q0.push_back(e);
                    q1.push_back(e);
                    n_acc++;
                end
                ovf_m = (ovf_m && !Clr_Err) || (Tx_Valid && ready[0] !== 1'b1);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        Tx_Data  = d;
        Tx_Valid = 1'b1;
        tick();
        Tx_Valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (!(busy[0] === 1'b0 && busy[1] === 1'b0 && empty[0] === 1'b1 &&
                 q0.size() == 0 && q1.size() == 0) && k < maxc) begin
            tick();
            k++;
        end
        if (k >= maxc) fail("idle_timeout: frames still pending");
        repeat (3) tick();
    endtask

    // Busy-high duration from the next rise; also samples Fifo_Empty at cycles p-1 and p.
    task automatic busy_len(input int p, output int len, output logic e_pre, output logic e_post);
        int k = 0;
        len    = 0;
        e_pre  = 1'bx;
        e_post = 1'bx;
        while (busy[0] !== 1'b1 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        while (busy[0] === 1'b1 && len < 2000) begin
            if (len == p - 1) e_pre = empty[0];
            if (len == p)     e_post = empty[0];
            len++;
            @(negedge Clk);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int   len, acc0;
        logic ep, eq;

        // Reset values
        repeat (3) tick();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_serial[%0d]", i), 32'(ser[i]), 32'd1);
            chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
            chk($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
            chk($sformatf("rst_empty[%0d]", i), 32'(empty[i]), 32'd1);
            chk($sformatf("rst_ready[%0d]", i), 32'(ready[i]), 32'd1);
            chk($sformatf("rst_ovf[%0d]", i), 32'(ovf[i]), 32'd0);
        end
        Rst     = 1'b0;
        started = 1'b1;
        repeat (2) tick();

        // 0xA5, 8N1, with first-bit latency
        Tx_Data  = 8'hA5;
        Tx_Valid = 1'b1;
        @(negedge Clk);
        chk("lat_pre_serial", 32'(ser[0]), 32'd1);
        tick();
        Tx_Valid = 1'b0;
        @(negedge Clk);
        chk("lat_n_serial", 32'(ser[0]), 32'd1);
        chk("lat_n_busy", 32'(busy[0]), 32'd0);
        @(negedge Clk);
        chk("lat_n1_serial", 32'(ser[0]), 32'd0);
        chk("lat_n1_busy", 32'(busy[0]), 32'd1);
        wait_idle(200);

        // 0x07, even parity, two stop bits
        Par_En = 1'b1; Par_Odd = 1'b0; Stop2 = 1'b1;
        Tx_Data  = 8'h07;
        Tx_Valid = 1'b1;
        fork
            begin tick(); Tx_Valid = 1'b0; end
            busy_len(0, len, ep, eq);
        join
        chk("frame_len_8e2", 32'(len), 32'd48);
        wait_idle(200);

        // Three back-to-back frames
        Par_En = 1'b0; Par_Odd = 1'b0; Stop2 = 1'b0;
        Tx_Data  = 8'h11;
        Tx_Valid = 1'b1;
        fork
            begin
                tick(); Tx_Data = 8'h22;
                tick(); Tx_Data = 8'h33;
                tick(); Tx_Valid = 1'b0;
            end
            busy_len(80, len, ep, eq);
        join
        chk("b2b_busy_len", 32'(len), 32'd120);
        chk("b2b_empty_before_pop3", 32'(ep), 32'd0);
        chk("b2b_empty_after_pop3", 32'(eq), 32'd1);
        wait_idle(300);

        // Overflow: six pushes against a depth-4 FIFO behind an active frame
        acc0     = n_acc;
        Tx_Valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Tx_Data = 8'($urandom);
            tick();
        end
        Tx_Valid = 1'b0;
        chk("ovf_accepted", 32'(n_acc - acc0), 32'd5);
        @(negedge Clk);
        chk("ovf_set", 32'(ovf[0]), 32'd1);
        tick();
        Clr_Err = 1'b1;
        tick();
        Clr_Err = 1'b0;
        @(negedge Clk);
        chk("ovf_cleared", 32'(ovf[0]), 32'd0);
        wait_idle(400);

        // Reset in the DATA state with a second word queued
        Tx_Data  = 8'h5A;
        Tx_Valid = 1'b1;
        tick();
        Tx_Data = 8'hC3;
        tick();
        Tx_Valid = 1'b0;
        repeat (12) tick();
        Rst = 1'b1;
        q0.delete();
        q1.delete();
        tick();
        @(negedge Clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("midrst_serial[%0d]", i), 32'(ser[i]), 32'd1);
            chk($sformatf("midrst_busy[%0d]", i), 32'(busy[i]), 32'd0);
            chk($sformatf("midrst_empty[%0d]", i), 32'(empty[i]), 32'd1);
        end
        tick();
        Rst = 1'b0;
        repeat (2) tick();
        push_word(8'h96);
        wait_idle(200);

        // Config change mid-frame applies only to the next frame
        Tx_Data  = 8'h3C;
        Tx_Valid = 1'b1;
        fork
            begin
                tick();
                Tx_Valid = 1'b0;
                repeat (10) tick();
                Par_En = 1'b1; Stop2 = 1'b1; Par_Odd = 1'b1;
                push_word(8'hE1);
            end
            busy_len(0, len, ep, eq);
        join
        chk("toggle_busy_len", 32'(len), 32'd88);
        wait_idle(300);

        // Randomized traffic; settings change only while the FIFO is empty
        for (int i = 0; i < 1500; i++) begin
            tick();
            Tx_Valid = ($urandom_range(0, 19) == 0);
            Tx_Data  = 8'($urandom);
            Clr_Err  = ($urandom_range(0, 49) == 0);
            if (empty[0] === 1'b1 && $urandom_range(0, 5) == 0) begin
                Par_En  = 1'($urandom);
                Par_Odd = 1'($urandom);
                Stop2   = 1'($urandom);
            end
        end
        tick();
        Tx_Valid = 1'b0;
        Clr_Err  = 1'b0;
        wait_idle(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
